poly_eval_pipe: RTL and testbench

//  Pipelined signed fixed-point polynomial evaluator: y = sum_{k=0..DEGREE} c_k * x^k via Horner's rule.

---
 rtl/poly_eval_pipe_if.sv | 25 ++
 rtl/poly_eval_pipe.sv | 122 ++++++++++++
 tb/tb_poly_eval_pipe.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/poly_eval_pipe_if.sv
// Valid/ready stream bundle for poly_eval_pipe: sample plus packed coefficients in, result plus overflow flag out.
// The master side drives samples and out_ready; the slave side (the evaluator) drives in_ready and the result.
interface poly_eval_pipe_if #(
   parameter int WIDTH  = 12,
   parameter int DEGREE = 3
);
   logic                        in_valid;
   logic                        in_ready;
   logic signed [WIDTH-1:0]     x;
   logic [(DEGREE+1)*WIDTH-1:0] coeff;
   logic                        out_valid;
   logic                        out_ready;
   logic signed [WIDTH-1:0]     out;
   logic                        ovf;

   modport master (
      output in_valid, x, coeff, out_ready,
      input  in_ready, out_valid, out, ovf
   );

   modport slave (
      input  in_valid, x, coeff, out_ready,
      output in_ready, out_valid, out, ovf
   );
endinterface

// File: rtl/poly_eval_pipe.sv
// Pipelined signed fixed-point Horner evaluator, one rank per degree, full-rate valid/ready stream.
// Build option POLY_EVAL_SAT_EN: saturate the result on overflow instead of forcing it to zero.
module poly_eval_pipe #(
   parameter int WIDTH  = 12,
   parameter int FRAC   = 0,
   parameter int DEGREE = 3
) (
   input  logic            clk_i,
   input  logic            rst_n_i,
   poly_eval_pipe_if.slave bus
);
   localparam int PW = 2 * WIDTH;
   localparam int SW = 2 * WIDTH + 1;
   // Rank j only carries the coefficients still to be added (c_0..c_{DEGREE-1-j}), so storage is triangular.
   localparam int CW = WIDTH * DEGREE * (DEGREE + 1) / 2;
   localparam logic signed [SW-1:0] MAX_S = {{(SW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
   localparam logic signed [SW-1:0] MIN_S = {{(SW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

   function automatic int coef_off(input int rank);
      return WIDTH * (rank * DEGREE - (rank * (rank - 1)) / 2);
   endfunction

   logic                    valid_q [0:DEGREE];
   logic                    valid_d [0:DEGREE];
   logic signed [WIDTH-1:0] acc_q   [0:DEGREE];
   logic signed [WIDTH-1:0] acc_d   [0:DEGREE];
   logic                    ovf_q   [0:DEGREE];
   logic                    ovf_d   [0:DEGREE];
   logic signed [WIDTH-1:0] x_q     [0:DEGREE-1];
   logic signed [WIDTH-1:0] x_d     [0:DEGREE-1];
   logic [CW-1:0]           coef_q;
   logic [CW-1:0]           coef_d;
   logic                    advance;
   logic                    accept;

   assign advance       = !valid_q[DEGREE] || bus.out_ready;
   assign accept        = bus.in_valid && advance;
   assign bus.in_ready  = advance;
   assign bus.out_valid = valid_q[DEGREE];
   assign bus.out       = acc_q[DEGREE];
   assign bus.ovf       = ovf_q[DEGREE];

   // Rank 0 loads the leading coefficient as the initial accumulator.
   assign valid_d[0]                  = accept;
   assign x_d[0]                      = bus.x;
   assign acc_d[0]                    = bus.coeff[DEGREE*WIDTH +: WIDTH];
   assign ovf_d[0]                    = 1'b0;
   assign coef_d[0 +: DEGREE*WIDTH]   = bus.coeff[0 +: DEGREE*WIDTH];

   for (genvar gi = 1; gi <= DEGREE; gi++) begin : g_stage
      localparam int IN_OFF = coef_off(gi - 1);
      localparam int NPASS  = DEGREE - gi;

      logic signed [WIDTH-1:0] c_k;
      logic signed [PW-1:0]    acc_ext;
      logic signed [PW-1:0]    x_ext;
      logic signed [PW-1:0]    prod;
      logic signed [PW-1:0]    q;
      logic signed [SW-1:0]    q_ext;
      logic signed [SW-1:0]    c_ext;
      logic signed [SW-1:0]    s;
      logic                    over;
      logic                    under;
      logic                    ovf_any;
      logic signed [WIDTH-1:0] sat;

      // The coefficient consumed here sits on top of what rank gi-1 still carries.
      assign c_k     = coef_q[IN_OFF + NPASS*WIDTH +: WIDTH];
      assign acc_ext = {{WIDTH{acc_q[gi-1][WIDTH-1]}}, acc_q[gi-1]};
      assign x_ext   = {{WIDTH{x_q[gi-1][WIDTH-1]}}, x_q[gi-1]};
      assign prod    = acc_ext * x_ext;
      assign q       = prod >>> FRAC;
      assign q_ext   = {q[PW-1], q};
      assign c_ext   = {{(SW-WIDTH){c_k[WIDTH-1]}}, c_k};
      assign s       = q_ext + c_ext;
      assign over    = s > MAX_S;
      assign under   = s < MIN_S;
      assign ovf_any = ovf_q[gi-1] | over | under;
      assign sat     = over  ? MAX_S[WIDTH-1:0] :
                       under ? MIN_S[WIDTH-1:0] : s[WIDTH-1:0];

      assign valid_d[gi] = valid_q[gi-1];
      assign ovf_d[gi]   = ovf_any;

      if (gi == DEGREE) begin : g_last
`ifdef POLY_EVAL_SAT_EN
         assign acc_d[gi] = sat;
`else
         assign acc_d[gi] = ovf_any ? '0 : sat;
`endif
      end else begin : g_mid
         assign acc_d[gi]                              = sat;
         assign x_d[gi]                                = x_q[gi-1];
         assign coef_d[coef_off(gi) +: NPASS*WIDTH]    = coef_q[IN_OFF +: NPASS*WIDTH];
      end
   end

   // Every rank moves together on advance; invalid slots carry don't-care data.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         for (int i = 0; i <= DEGREE; i++) begin
            valid_q[i] <= 1'b0;
            acc_q[i]   <= '0;
            ovf_q[i]   <= 1'b0;
         end
         for (int i = 0; i < DEGREE; i++) begin
            x_q[i] <= '0;
         end
         coef_q <= '0;
      end else if (advance) begin
         for (int i = 0; i <= DEGREE; i++) begin
            valid_q[i] <= valid_d[i];
            acc_q[i]   <= acc_d[i];
            ovf_q[i]   <= ovf_d[i];
         end
         for (int i = 0; i < DEGREE; i++) begin
            x_q[i] <= x_d[i];
         end
         coef_q <= coef_d;
      end
   end
endmodule

// File: tb/tb_poly_eval_pipe.sv
// Bench for poly_eval_pipe: directed cases, a streamed stall case, reset flush, and a random run
// scored against a plain-arithmetic Horner model (WIDTH=12, DEGREE=3; second instance with FRAC=8).
module tb_poly_eval_pipe;
   typedef struct {
      int out;
      bit ovf;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   failures = 0;
   int   n_out = 0;
   exp_t sb[$];
   bit   holding = 1'b0;
   int   held_out = 0;
   bit   held_ovf = 1'b0;
   bit   done = 1'b0;

   always #5 clk = ~clk;

   poly_eval_pipe_if #(.WIDTH(12), .DEGREE(3)) bus ();
   poly_eval_pipe_if #(.WIDTH(12), .DEGREE(3)) bus8 ();

   poly_eval_pipe #(.WIDTH(12), .FRAC(0), .DEGREE(3)) dut (
      .clk_i(clk), .rst_n_i(rst_n), .bus(bus)
   );
   poly_eval_pipe #(.WIDTH(12), .FRAC(8), .DEGREE(3)) dut8 (
      .clk_i(clk), .rst_n_i(rst_n), .bus(bus8)
   );

   // Horner evaluation on 64-bit integers, clamping to 12-bit signed after every step.
   function automatic void model(input logic signed [11:0] xv, input logic [47:0] cv, input int frac,
                                 output int m_out, output bit m_ovf);
      logic signed [11:0] c;
      longint acc;
      longint ck;
      c = cv[36 +: 12];
      acc = c;
      m_ovf = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         c = cv[(3-k)*12 +: 12];
         ck = c;
         acc = (acc * xv) >>> frac;
         acc = acc + ck;
         if (acc > 2047) begin acc = 2047; m_ovf = 1'b1; end
         else if (acc < -2048) begin acc = -2048; m_ovf = 1'b1; end
      end
`ifdef POLY_EVAL_SAT_EN
      m_out = int'(acc);
`else
      m_out = m_ovf ? 0 : int'(acc);
`endif
   endfunction

   function automatic logic [47:0] pack(input logic [11:0] c0, input logic [11:0] c1,
                                        input logic [11:0] c2, input logic [11:0] c3);
      return {c3, c2, c1, c0};
   endfunction

   task automatic check_val(input string name, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d, expected %0d", name, got, exp);
      end
   endtask

   // Scoreboard: one compare process on every falling edge.
   always @(negedge clk) begin
      exp_t e;
      int   mo;
      bit   mv;
      if (!rst_n) begin
         sb.delete();
         holding = 1'b0;
      end else begin
         check_val("in_ready_rule", bus.in_ready, (!bus.out_valid || bus.out_ready) ? 1 : 0);
         if (holding) begin
            check_val("stall_valid", bus.out_valid, 1);
            check_val("stall_out", bus.out, held_out);
            check_val("stall_ovf", bus.ovf, held_ovf);
         end
         if (bus.out_valid) begin
            if (sb.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_output: got out=%0d with nothing pending, expected no output", bus.out);
            end else if (bus.out_ready) begin
               e = sb.pop_front();
               n_out++;
               check_val("out_vs_model", bus.out, e.out);
               check_val("ovf_vs_model", bus.ovf, e.ovf);
            end
         end
         holding  = bus.out_valid && !bus.out_ready;
         held_out = bus.out;
         held_ovf = bus.ovf;
         if (bus.in_valid && bus.in_ready) begin
            model(bus.x, bus.coeff, 0, mo, mv);
            e.out = mo;
            e.ovf = mv;
            sb.push_back(e);
         end
      end
   end

   task automatic send(input logic [11:0] xv, input logic [47:0] cv);
      int n = 0;
      bus.in_valid = 1'b1;
      bus.x        = xv;
      bus.coeff    = cv;
      @(negedge clk);
      while (!bus.in_ready && n < 100) begin
         n++;
         @(negedge clk);
      end
      if (!bus.in_ready) begin
         checks++;
         failures++;
         $display("FAIL send_timeout: got in_ready=0 for %0d cycles, expected 1", n);
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while ((sb.size() != 0 || bus.out_valid) && n < 300) begin
         @(posedge clk);
         #1;
         n++;
      end
      checks++;
      if (sb.size() != 0 || bus.out_valid) begin
         failures++;
         $display("FAIL drain: got pending=%0d out_valid=%0b, expected 0 and 0", sb.size(), bus.out_valid);
      end
   endtask

   task automatic run_one(input string name, input logic [11:0] xv, input logic [47:0] cv,
                          input int exp_out, input int exp_ovf);
      int n = 0;
      drain();
      send(xv, cv);
      while (!bus.out_valid && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      check_val({name, "_valid"}, bus.out_valid, 1);
      check_val({name, "_out"}, bus.out, exp_out);
      check_val({name, "_ovf"}, bus.ovf, exp_ovf);
   endtask

   task automatic run8(input string name, input logic [11:0] xv, input logic [47:0] cv, input int exp_out);
      int n = 0;
      bus8.in_valid = 1'b1;
      bus8.x        = xv;
      bus8.coeff    = cv;
      @(posedge clk);
      #1;
      bus8.in_valid = 1'b0;
      while (!bus8.out_valid && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      check_val({name, "_latency"}, n, 3);
      check_val({name, "_out"}, bus8.out, exp_out);
      check_val({name, "_ovf"}, bus8.ovf, 0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish by time limit, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int mo;
      bit mv;
      int n0;
      int t;
      logic [11:0] xv;
      logic [47:0] cv;
      int sat_exp;

      rst_n = 1'b0;
      bus.in_valid = 1'b0;  bus.x = '0;  bus.coeff = '0;  bus.out_ready = 1'b1;
      bus8.in_valid = 1'b0; bus8.x = '0; bus8.coeff = '0; bus8.out_ready = 1'b1;
`ifdef POLY_EVAL_SAT_EN
      sat_exp = 2047;
`else
      sat_exp = 0;
`endif

      // Pin the model against hand-computed values.
      model(12'd2, pack(12'd1, 12'd2, 12'd3, 12'd1), 0, mo, mv);
      check_val("pin_model_25", mo, 25);
      model(12'h180, pack(12'd0, 12'd0, 12'h100, 12'd0), 8, mo, mv);
      check_val("pin_model_frac", mo, 576);
      model(12'd100, pack(12'd0, 12'd0, 12'd0, 12'd1), 0, mo, mv);
      check_val("pin_model_ovf", mv, 1);
      check_val("pin_model_ovf_out", mo, sat_exp);

      repeat (3) @(posedge clk);
      #1;
      check_val("reset_out_valid", bus.out_valid, 0);
      check_val("reset_out", bus.out, 0);
      check_val("reset_ovf", bus.ovf, 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check_val("reset_in_ready", bus.in_ready, 1);

      // Basic cubic with exact three-cycle latency.
      drain();
      send(12'd2, pack(12'd1, 12'd2, 12'd3, 12'd1));
      for (int i = 0; i < 3; i++) begin
         check_val("t1_not_yet_valid", bus.out_valid, 0);
         @(posedge clk);
         #1;
      end
      check_val("t1_valid", bus.out_valid, 1);
      check_val("t1_out", bus.out, 25);
      check_val("t1_ovf", bus.ovf, 0);

      run_one("t2_neg_cube", 12'hFFE, pack(12'd0, 12'd0, 12'd0, 12'd1), -8, 0);
      run_one("t2_neg_square", 12'hFFD, pack(12'd0, 12'd0, 12'd1, 12'd0), 9, 0);
      run_one("t3_overflow", 12'd100, pack(12'd0, 12'd0, 12'd0, 12'd1), sat_exp, 1);
      run_one("edge_max", 12'd1, pack(12'd0, 12'd0, 12'd0, 12'd2047), 2047, 0);
      run_one("edge_min", 12'd0, pack(12'h800, 12'd0, 12'd0, 12'd0), -2048, 0);
      run_one("edge_plus1", 12'd1, pack(12'd0, 12'd0, 12'd1, 12'd2047), sat_exp, 1);

      run8("t4_frac", 12'h180, pack(12'd0, 12'd0, 12'h100, 12'd0), 576);
      run8("t4_floor", 12'hF80, pack(12'd0, 12'd1, 12'd0, 12'd0), -1);

      // Back-to-back stream with a three-cycle output stall.
      drain();
      n0 = n_out;
      fork
         begin
            for (int i = 1; i <= 10; i++) send(12'(i), pack(12'd1, 12'd2, 12'd3, 12'd1));
         end
         begin
            repeat (5) @(posedge clk);
            #1;
            bus.out_ready = 1'b0;
            for (int i = 0; i < 3; i++) begin
               @(negedge clk);
               check_val("t5_in_ready_stall", bus.in_ready, 0);
               check_val("t5_out_valid_stall", bus.out_valid, 1);
               @(posedge clk);
               #1;
            end
            bus.out_ready = 1'b1;
         end
      join
      drain();
      check_val("t5_count", n_out - n0, 10);

      // Random traffic with random back-pressure.
      n0 = n_out;
      done = 1'b0;
      fork
         begin
            for (int i = 0; i < 200; i++) begin
               if ($urandom_range(0, 1) == 0) begin
                  t  = int'($urandom_range(0, 12)) - 6;
                  xv = 12'(t);
                  for (int k = 0; k < 4; k++) begin
                     t = int'($urandom_range(0, 40)) - 20;
                     cv[k*12 +: 12] = 12'(t);
                  end
               end else begin
                  xv = 12'($urandom);
                  cv = {16'($urandom), $urandom};
               end
               send(xv, cv);
               if ($urandom_range(0, 3) == 0) begin
                  repeat ($urandom_range(1, 3)) begin
                     @(posedge clk);
                     #1;
                  end
               end
            end
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(posedge clk);
               #1;
               bus.out_ready = ($urandom_range(0, 3) != 0);
            end
            bus.out_ready = 1'b1;
         end
      join
      drain();
      check_val("rand_count", n_out - n0, 200);

      // Reset with three samples in flight, one of them on the output.
      bus.out_ready = 1'b0;
      send(12'd2, pack(12'd1, 12'd2, 12'd3, 12'd1));
      send(12'd100, pack(12'd0, 12'd0, 12'd0, 12'd1));
      send(12'd3, pack(12'd0, 12'd0, 12'd0, 12'd1));
      @(posedge clk);
      #1;
      check_val("t6_pre_valid", bus.out_valid, 1);
      rst_n = 1'b0;
      #1;
      check_val("t6_rst_out_valid", bus.out_valid, 0);
      check_val("t6_rst_out", bus.out, 0);
      check_val("t6_rst_ovf", bus.ovf, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         check_val("t6_no_stale", bus.out_valid, 0);
      end
      run_one("t6_after", 12'd2, pack(12'd1, 12'd2, 12'd3, 12'd1), 25, 0);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
